seq_demux7: RTL



---
 rtl/seq_demux7.sv | 95 +++++++++
 1 files changed

// File: rtl/seq_demux7.sv
// seq_demux7: registered 1-to-7 demultiplexer.
// One input stream is routed into seven one-entry channel buffers, each with
// its own valid/ready handshake. The target channel comes either from the
// external select (with 3'b111 aliased to channel 0) or from an internal
// round-robin pointer that walks 0..6 on every accepted word.

module seq_demux7 #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       sel,
    input  logic             auto_en,
    input  logic             seq_clr,
    output logic [7*W-1:0]   out_data,
    output logic [6:0]       out_valid,
    input  logic [6:0]       out_ready,
    output logic [2:0]       cur_sel
);

    logic [7*W-1:0] data_q;
    logic [7*W-1:0] data_d;
    logic [6:0]     valid_q;
    logic [6:0]     valid_d;
    logic [2:0]     seq_ptr_q;
    logic [2:0]     seq_ptr_d;

    logic [2:0]     esel;
    logic [7:0]     valid_ext;
    logic [7:0]     ready_ext;
    logic           accept;

    // Effective channel select; manual select 3'b111 folds onto channel 0.
    always_comb begin
        esel = 3'd0;
        if (auto_en) begin
            esel = seq_ptr_q;
        end else if (sel != 3'b111) begin
            esel = sel;
        end
    end

    // Padding to eight entries keeps every select value a legal index.
    assign valid_ext = {1'b0, valid_q};
    assign ready_ext = {1'b0, out_ready};

    // The selected buffer takes a word when empty or being drained this cycle.
    always_comb begin
        in_ready = !valid_ext[esel] || ready_ext[esel];
        accept   = in_valid && in_ready;
    end

    // Next buffer state: every channel drains on its own, at most one loads.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q & ~out_ready;
        for (int k = 0; k < 7; k++) begin
            if (accept && (esel == 3'(k))) begin
                data_d[k*W +: W] = in_data;
                valid_d[k]       = 1'b1;
            end
        end
    end

    // Sequence pointer: clear wins, otherwise advance 0..6 on auto-mode accepts.
    always_comb begin
        seq_ptr_d = seq_ptr_q;
        if (seq_clr) begin
            seq_ptr_d = 3'd0;
        end else if (accept && auto_en) begin
            seq_ptr_d = (seq_ptr_q == 3'd6) ? 3'd0 : seq_ptr_q + 3'd1;
        end
    end

    // State registers; reset discards all buffered words at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q    <= '0;
            valid_q   <= '0;
            seq_ptr_q <= '0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            seq_ptr_q <= seq_ptr_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign cur_sel   = esel;

endmodule
